rib_dmem_slave: RTL

- Data-memory responder on the RIB load/store bus. It is the target end of the read request the ID/EX stage issues (read request plus address) and of the store request issued from EX.
- Holds a word-organised RAM and serves one transaction at a time, with a programmable number of wait states.
- Returns read data, write acknowledge and error status, and raises a hold request to pipeline control while a transaction is outstanding.

---
 rtl/rib_dmem_slave.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rib_dmem_slave.sv
// RIB data-memory target: word RAM, one transaction at a time, response WAIT_CYCLES+1 cycles after the IDLE sample.
// Backpressure: hold_req_o stalls the pipeline until the response cycle; a request dropped during WAIT aborts with no response.
module rib_dmem_slave #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_req_i,
    input  logic [31:0] mem_rd_addr_i,
    input  logic        mem_wr_req_i,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_wr_data_i,
    input  logic [3:0]  mem_wr_sel_i,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_rd_valid_o,
    output logic        mem_wr_ack_o,
    output logic        mem_err_o,
    output logic        hold_req_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        op_wr_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  sel_q;
    logic        err_q;
    logic [31:0] rd_q;

    logic [31:0] ram [DEPTH_WORDS];

    logic        in_idle;
    logic        sample;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic [3:0]  acc_sel;
    logic [29:0] word_off;
    logic        acc_in_range;
    logic [AW-1:0] idx;
    logic        req_held;
    logic        ram_en;

    // In IDLE the access comes straight from the bus so WAIT_CYCLES=0 can hit the RAM on the sampling edge.
    assign in_idle  = (state_q == ST_IDLE);
    assign sample   = in_idle && (mem_wr_req_i || mem_rd_req_i);
    assign acc_wr   = in_idle ? mem_wr_req_i : op_wr_q;
    assign acc_addr = in_idle ? (mem_wr_req_i ? mem_wr_addr_i : mem_rd_addr_i) : addr_q;
    assign acc_data = in_idle ? mem_wr_data_i : data_q;
    assign acc_sel  = in_idle ? mem_wr_sel_i : sel_q;

    assign word_off     = 30'((acc_addr - BASE_ADDR) >> 2);
    assign acc_in_range = (acc_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    assign idx          = word_off[AW-1:0];
    assign req_held     = op_wr_q ? mem_wr_req_i : mem_rd_req_i;
    assign ram_en       = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (!req_held)          state_d = ST_IDLE;
                else if (cnt_q == 4'd0) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            sel_q   <= 4'd0;
            err_q   <= 1'b0;
        end else if (sample) begin
            cnt_q   <= CNT_LOAD;
            op_wr_q <= mem_wr_req_i;
            addr_q  <= acc_addr;
            data_q  <= mem_wr_data_i;
            sel_q   <= mem_wr_sel_i;
            err_q   <= !acc_in_range;
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Single-port RAM: exactly one access, on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (acc_wr) begin
                if (acc_in_range) begin
                    for (int n = 0; n < 4; n++) begin
                        if (acc_sel[n]) ram[idx][8*n +: 8] <= acc_data[8*n +: 8];
                    end
                end
            end else begin
                rd_q <= ram[idx];
            end
        end
    end

    always_comb begin
        mem_rd_valid_o = (state_q == ST_RESP) && !op_wr_q;
        mem_wr_ack_o   = (state_q == ST_RESP) && op_wr_q;
        mem_err_o      = (state_q == ST_RESP) && err_q;
        mem_rd_data_o  = (mem_rd_valid_o && !err_q) ? rd_q : 32'd0;
        hold_req_o     = (in_idle && (mem_rd_req_i || mem_wr_req_i)) || (state_q == ST_WAIT);
    end

endmodule
